// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data access share one
// single-command-per-cycle memory port. Data wins contention, but an
// instruction request that has lost STARVE_MAX times in a row is forced through.
// Read responses return one cycle after the grant and are routed by a tag.
module mem_arbiter #(
  parameter int WORD_LEN   = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic                d_wen,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WORD_LEN-1:0] d_rdata,
  input  logic                m_ready,
  output logic                m_en,
  output logic [WORD_LEN-1:0] m_addr,
  output logic                m_wen,
  output logic [WORD_LEN-1:0] m_wdata,
  input  logic [WORD_LEN-1:0] m_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          tag_vld;   // a read response is due this cycle
  logic          tag_own;   // 1 = data port owns it, 0 = instruction port
  logic          i_starved;

  assign i_starved = (starve_cnt == STARVE_LIM);

  // Pick at most one winner; nothing is granted while memory is busy or in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst && m_ready) begin
      if (i_req && (!d_req || i_starved)) i_gnt = 1'b1;
      else if (d_req)                     d_gnt = 1'b1;
    end
  end

  // Steer the winner's command onto the memory port; idle port drives zeros.
  always_comb begin
    m_en    = i_gnt | d_gnt;
    m_addr  = '0;
    m_wen   = 1'b0;
    m_wdata = '0;
    if (i_gnt) begin
      m_addr = i_addr;
    end else if (d_gnt) begin
      m_addr  = d_addr;
      m_wen   = d_wen;
      m_wdata = d_wdata;
    end
  end

  // Count consecutive losses of a waiting fetch to data; a stalled memory freezes it.
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (!i_req || i_gnt)
      starve_cnt <= '0;
    else if (m_ready && d_gnt && !i_starved)
      starve_cnt <= starve_cnt + SW'(1);
  end

  // Remember who owns the read issued this cycle; stores complete at grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= 1'b0;
      tag_own <= 1'b0;
    end else begin
      tag_vld <= i_gnt | (d_gnt & ~d_wen);
      tag_own <= d_gnt;
    end
  end

  // Route returning read data to its owner; the other port reads zero.
  always_comb begin
    i_rvalid = !rst && tag_vld && !tag_own;
    d_rvalid = !rst && tag_vld &&  tag_own;
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rdata  = d_rvalid ? m_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all continuously compared against a behavioural model.
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int SM = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, d_req, d_wen, m_ready;
  logic [W-1:0] i_addr, d_addr, d_wdata, m_rdata;
  logic         i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_wen;
  logic [W-1:0] i_rdata, d_rdata, m_addr, m_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.WORD_LEN(W), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_ready(m_ready), .m_en(m_en), .m_addr(m_addr), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: how many times in a row the fetch has lost, and
  // which port (if any) is owed read data next cycle.
  int lose     = 0;
  bit owe_i    = 1'b0;
  bit owe_d    = 1'b0;

  // Per-cycle compare against the model, then advance the model past the next edge.
  always @(negedge clk) begin
    bit ei, ed;
    if (rst) begin
      chk("rst_i_gnt", W'(i_gnt), '0);     chk("rst_d_gnt", W'(d_gnt), '0);
      chk("rst_m_en", W'(m_en), '0);       chk("rst_m_wen", W'(m_wen), '0);
      chk("rst_m_addr", m_addr, '0);       chk("rst_m_wdata", m_wdata, '0);
      chk("rst_i_rvalid", W'(i_rvalid), '0);
      chk("rst_d_rvalid", W'(d_rvalid), '0);
      lose = 0; owe_i = 0; owe_d = 0;
    end else begin
      ei = m_ready && i_req && (!d_req || lose >= SM);
      ed = m_ready && d_req && !ei;
      chk("m_i_gnt", W'(i_gnt), W'(ei));
      chk("m_d_gnt", W'(d_gnt), W'(ed));
      chk("m_m_en", W'(m_en), W'(ei || ed));
      chk("m_m_addr", m_addr, ei ? i_addr : ed ? d_addr : '0);
      chk("m_m_wen", W'(m_wen), W'(ed && d_wen));
      chk("m_m_wdata", m_wdata, ed ? d_wdata : '0);
      chk("m_i_rvalid", W'(i_rvalid), W'(owe_i));
      chk("m_d_rvalid", W'(d_rvalid), W'(owe_d));
      chk("m_i_rdata", i_rdata, owe_i ? m_rdata : '0);
      chk("m_d_rdata", d_rdata, owe_d ? m_rdata : '0);
      if (!i_req || ei)   lose = 0;
      else if (ed)        lose = (lose + 1 > SM) ? SM : lose + 1;
      owe_i = ei;
      owe_d = ed && !d_wen;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    i_req = 0; d_req = 0; d_wen = 0; m_ready = 1;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
  endtask

  initial begin
    string pat;
    rst = 1; idle();
    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("reset_m_en", W'(m_en), '0);
    chk("reset_i_rvalid", W'(i_rvalid), '0);
    step(); rst = 0;

    // Solo fetch
    i_req = 1; i_addr = 32'h100;
    @(negedge clk);
    chk("fetch_i_gnt", W'(i_gnt), 32'h1);
    chk("fetch_m_addr", m_addr, 32'h100);
    chk("fetch_m_wen", W'(m_wen), 32'h0);
    step(); i_req = 0; m_rdata = 32'h13;
    @(negedge clk);
    chk("fetch_i_rvalid", W'(i_rvalid), 32'h1);
    chk("fetch_i_rdata", i_rdata, 32'h13);
    chk("fetch_no_d_rvalid", W'(d_rvalid), 32'h0);

    // Contention: three data wins then one fetch, repeating
    step(); i_req = 1; d_req = 1; d_wen = 0; i_addr = 32'h200; d_addr = 32'h300;
    pat = "";
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      @(negedge clk);
      pat = {pat, i_gnt ? "i" : d_gnt ? "d" : "-"};
    end
    n_chk++;
    if (pat != "dddidddi") begin
      n_fail++;
      $display("FAIL contention_pattern: got %s expected dddidddi", pat);
    end

    // Store
    step(); idle(); d_req = 1; d_wen = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("store_d_gnt", W'(d_gnt), 32'h1);
    chk("store_m_wen", W'(m_wen), 32'h1);
    chk("store_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("store_m_addr", m_addr, 32'h2000);
    step(); idle();
    @(negedge clk);
    chk("store_no_d_rvalid", W'(d_rvalid), 32'h0);

    // Stall: two data wins, 5 stalled cycles, then one more data win and the fetch
    step(); i_req = 1; d_req = 1; i_addr = 32'h400; d_addr = 32'h500;
    step(); step();
    m_ready = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_i_gnt", W'(i_gnt), 32'h0);
      chk("stall_d_gnt", W'(d_gnt), 32'h0);
      chk("stall_m_en", W'(m_en), 32'h0);
      step();
    end
    m_ready = 1;
    @(negedge clk);
    chk("resume_d_gnt", W'(d_gnt), 32'h1);
    step();
    @(negedge clk);
    chk("resume_i_gnt", W'(i_gnt), 32'h1);

    // Reset mid-operation discards the fetch response
    step(); idle(); i_req = 1; i_addr = 32'h600;
    @(negedge clk);
    chk("midrst_i_gnt", W'(i_gnt), 32'h1);
    step(); rst = 1; m_rdata = 32'h55;
    @(negedge clk);
    chk("midrst_i_rvalid", W'(i_rvalid), 32'h0);
    chk("midrst_m_en", W'(m_en), 32'h0);
    step(); rst = 0; i_req = 0;
    @(negedge clk);
    chk("postrst_i_rvalid", W'(i_rvalid), 32'h0);

    // Back-to-back loads
    step(); idle(); d_req = 1; d_addr = 32'h10;
    @(negedge clk);
    chk("b2b_gnt0", W'(d_gnt), 32'h1);
    step(); d_addr = 32'h14; m_rdata = 32'hA0;
    @(negedge clk);
    chk("b2b_gnt1", W'(d_gnt), 32'h1);
    chk("b2b_addr1", m_addr, 32'h14);
    chk("b2b_rv0", W'(d_rvalid), 32'h1);
    chk("b2b_rd0", d_rdata, 32'hA0);
    step(); d_req = 0; m_rdata = 32'hA4;
    @(negedge clk);
    chk("b2b_rv1", W'(d_rvalid), 32'h1);
    chk("b2b_rd1", d_rdata, 32'hA4);

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      step();
      rst     = ($urandom_range(0, 199) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      i_req   = $urandom_range(0, 1) == 1;
      d_req   = $urandom_range(0, 3) != 0;
      d_wen   = $urandom_range(0, 2) == 0;
      i_addr  = $urandom; d_addr = $urandom;
      d_wdata = $urandom; m_rdata = $urandom;
    end
    step(); rst = 0; idle();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, address/data width.
REQ-002 SHALL have parameter STARVE_MAX, default 3, max consecutive cycles an instruction request may lose to data.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_req, input, 1, instruction fetch request.
REQ-006 SHALL have port i_addr, input, WORD_LEN, fetch address.
REQ-007 SHALL have port i_gnt, output, 1, fetch accepted this cycle.
REQ-008 SHALL have port i_rvalid, output, 1, fetch data valid.
REQ-009 SHALL have port i_rdata, output, WORD_LEN, fetch data.
REQ-010 SHALL have port d_req, input, 1, data access request.
REQ-011 SHALL have port d_addr, input, WORD_LEN, data address.
REQ-012 SHALL have port d_wen, input, 1, 1 = store, 0 = load.
REQ-013 SHALL have port d_wdata, input, WORD_LEN, store data.
REQ-014 SHALL have port d_gnt, output, 1, data access accepted this cycle.
REQ-015 SHALL have port d_rvalid, output, 1, load data valid.
REQ-016 SHALL have port d_rdata, output, WORD_LEN, load data.
REQ-017 SHALL have port m_ready, input, 1, memory can accept a command this cycle.
REQ-018 SHALL have port m_en, output, 1, memory command valid.
REQ-019 SHALL have port m_addr, output, WORD_LEN, memory address.
REQ-020 SHALL have port m_wen, output, 1, memory write enable.
REQ-021 SHALL have port m_wdata, output, WORD_LEN, memory write data.
REQ-022 SHALL have port m_rdata, input, WORD_LEN, memory read data, valid exactly one cycle after an accepted read command.

Function
REQ-023 SHALL grant at most one requester per cycle; grants, m_en, m_addr, m_wen and m_wdata combinational from current inputs and state.
REQ-024 SHALL issue no command and assert no grant while m_ready = 0; requests held by requesters until granted.
REQ-025 SHALL, with m_ready = 1 and only one request, grant that requester.
REQ-026 SHALL, with m_ready = 1 and both requesting, grant data unless starve_cnt == STARVE_MAX, then grant instruction.
REQ-027 SHALL drive m_en = 1 with the granted requester's address; m_wen = d_wen and m_wdata = d_wdata on data grant; m_wen = 0 on instruction grant; m_wen = 0 when no grant.
REQ-028 SHALL keep starve_cnt: increment (saturating at STARVE_MAX) when i_req = 1, m_ready = 1 and d_gnt = 1; clear on i_gnt or i_req = 0; hold while m_ready = 0.
REQ-029 SHALL register a response tag {valid, owner} on each granted read (instruction or data load); stores produce no tag.
REQ-030 SHALL, in the cycle after a granted read, assert exactly one of i_rvalid/d_rvalid for one cycle per the tag, driving the matching rdata = m_rdata.
REQ-031 SHALL support back-to-back grants: a new grant may issue in the same cycle a prior response is returned.
REQ-032 SHALL drive i_rdata/d_rdata to 0 when the corresponding rvalid = 0.
REQ-033 SHALL complete a store at grant; d_rvalid not asserted for stores.

Reset
REQ-034 SHALL, while rst = 1, force i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_wen to 0, m_addr/m_wdata to 0, starve_cnt to 0, tag valid to 0.
REQ-035 SHALL discard any in-flight response at reset; no rvalid in the cycle after rst deasserts.

Verification
REQ-036 SHALL test solo fetch: i_req=1, i_addr=0x100, m_ready=1, m_rdata=0x00000013 next cycle -> i_gnt=1, m_addr=0x100, then i_rvalid=1, i_rdata=0x13.
REQ-037 SHALL test contention: i_req=d_req=1 continuously, d_wen=0 -> d granted 3 cycles, instruction granted 4th cycle, pattern repeats.
REQ-038 SHALL test store: d_req=1, d_wen=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> d_gnt=1, m_wen=1, m_wdata=0xDEADBEEF, no d_rvalid next cycle.
REQ-039 SHALL test stall: m_ready=0 for 5 cycles with both requesting -> no grants, starve_cnt unchanged; m_ready=1 -> normal arbitration resumes.
REQ-040 SHALL test reset mid-operation: grant a fetch, assert rst next cycle -> all outputs 0, no i_rvalid after rst deasserts.
REQ-041 SHALL test back-to-back loads at 0x10, 0x14 -> d_rvalid on two consecutive cycles with matching data, order preserved.
